// File: rtl/vector_pkg.sv
// Shared types and constants for the vector list player.
// Optional feature macro: VECLIST_FRAME_SYNC_EN adds a SYNC state.
package vector_pkg;

  // Default coordinate width of the line drawer.
  localparam int DEFAULT_COORD_W = 12;

  // Command opcodes stored in the top two bits of each list entry.
  typedef enum logic [1:0] {
    OP_DRAW = 2'b00,
    OP_JUMP = 2'b01,
    OP_END  = 2'b10,
    OP_NOP  = 2'b11
  } vec_op_t;

  // Layout of one list entry at the default coordinate width.
  typedef struct packed {
    vec_op_t                    op;
    logic [DEFAULT_COORD_W-1:0] x;
    logic [DEFAULT_COORD_W-1:0] y;
  } vec_entry_t;

  // Sequencer states, kept as plain constants so older tools accept them.
  typedef logic [2:0] vec_state_t;
  localparam vec_state_t ST_IDLE   = 3'd0;
  localparam vec_state_t ST_FETCH  = 3'd1;
  localparam vec_state_t ST_DECODE = 3'd2;
  localparam vec_state_t ST_ISSUE  = 3'd3;
  localparam vec_state_t ST_HOLD   = 3'd4;
  localparam vec_state_t ST_WAIT   = 3'd5;
`ifdef VECLIST_FRAME_SYNC_EN
  localparam vec_state_t ST_SYNC   = 3'd6;
`endif

endpackage

// File: rtl/vector_list_ram.sv
// Simple dual-port command list: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module vector_list_ram #(
  parameter int WIDTH  = 26,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write and registered read share one edge so the read sees pre-write data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vector_list_player.sv
// Plays a writable list of DRAW/JUMP/NOP/END commands to a line drawer
// over the x/y/draw/jump/ready handshake, with looping and clean stop.
// Optional feature macro: VECLIST_FRAME_SYNC_EN (frame_sync input + SYNC state).
module vector_list_player
  import vector_pkg::*;
#(
  parameter int COORD_W = DEFAULT_COORD_W,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [2+2*COORD_W-1:0] wr_data,
  input  logic                   ready,
`ifdef VECLIST_FRAME_SYNC_EN
  input  logic                   frame_sync,
`endif
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  output logic                   draw,
  output logic                   jump,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);

  localparam int               EW   = 2 + 2*COORD_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  vec_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic                is_jump_q, is_jump_d;
  logic                draw_q, draw_d, jump_q, jump_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                stop_q, stop_d;
  logic                stop_seen, end_frame;
  logic [EW-1:0]       rd_data;
  vec_op_t             rd_op;

  vector_list_ram #(.WIDTH(EW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

  assign rd_op     = vec_op_t'(rd_data[EW-1 -: 2]);
  // A stop arriving this cycle counts as latched so it is honoured promptly.
  assign stop_seen = stop_q | stop;

  // Next-state, address, coordinate and pulse logic.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    x_d           = x_q;
    y_d           = y_q;
    is_jump_d     = is_jump_q;
    draw_d        = 1'b0;
    jump_d        = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    stop_d        = stop_seen;
    end_frame     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Idle always consumes any stop, including one paired with start.
        stop_d = 1'b0;
        addr_d = '0;
        if (start && !stop_seen) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (rd_op)
          OP_DRAW, OP_JUMP: begin
            x_d       = rd_data[2*COORD_W-1 -: COORD_W];
            y_d       = rd_data[COORD_W-1:0];
            is_jump_d = (rd_op == OP_JUMP);
            state_d   = ST_ISSUE;
          end
          OP_NOP: begin
            if (addr_q == LAST) begin
              end_frame = 1'b1;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end
          default: end_frame = 1'b1;
        endcase
      end
      ST_ISSUE: begin
        if (ready) begin
          draw_d  = !is_jump_q;
          jump_d  = is_jump_q;
          state_d = ST_HOLD;
        end
      end
      // The drawer needs a cycle to drop ready after a pulse.
      ST_HOLD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ready) begin
          if (addr_q == LAST) begin
            end_frame = 1'b1;
          end else if (stop_seen) begin
            addr_d  = '0;
            stop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
`ifdef VECLIST_FRAME_SYNC_EN
      ST_SYNC: begin
        if (stop_seen) begin
          stop_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (frame_sync) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Explicit END and running off the end of the list share this path.
    if (end_frame) begin
      frame_done_d  = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
      addr_d        = '0;
      if (loop_en && !stop_seen) begin
`ifdef VECLIST_FRAME_SYNC_EN
        state_d = ST_SYNC;
`else
        state_d = ST_FETCH;
`endif
      end else begin
        stop_d  = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  // State and output registers; reset abandons any in-flight command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      is_jump_q     <= 1'b0;
      draw_q        <= 1'b0;
      jump_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      stop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      x_q           <= x_d;
      y_q           <= y_d;
      is_jump_q     <= is_jump_d;
      draw_q        <= draw_d;
      jump_q        <= jump_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      stop_q        <= stop_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign draw        = draw_q;
  assign jump        = jump_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
